ex_muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_step.sv | 40 ++++
 rtl/ex_muldiv_unit.sv | 137 +++++++++++++
 tb/tb_ex_muldiv_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide engine:
// opcode encodings, FSM state type and default datapath width.
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring
// trial-subtract for divide, on a shared 2*WIDTH accumulator.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               div,
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_out
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    // Divide: {rem,quo} shifts left, keep the difference when no borrow.
    // Multiply: add multiplicand on LSB, then shift right with carry.
    always_comb begin
        sum     = '0;
        trial   = '0;
        diff    = '0;
        acc_out = acc_in;
        if (div) begin
            trial = acc_in[2*WIDTH-1:WIDTH-1];
            diff  = trial - {1'b0, operand};
            if (!diff[WIDTH]) begin
                acc_out = {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
            end else begin
                acc_out = {trial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
            end
        end else begin
            sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]}
                + (acc_in[0] ? {1'b0, operand} : '0);
            acc_out = {sum, acc_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine for the EX stage.
// Stalls the front end via busy_out and holds HI/LO between ops.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_in,
    input  logic [1:0]       op_in,
    input  logic [WIDTH-1:0] data1_in,
    input  logic [WIDTH-1:0] data2_in,
    input  logic             abort_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             dbz_out
);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 div_q;
    logic                 neg_res;
    logic                 neg_a;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opnd;
    logic [2*WIDTH-1:0]   acc_nxt;

    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rem;
    logic                 dbz;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div     (div_q),
        .acc_in  (acc),
        .operand (opnd),
        .acc_out (acc_nxt)
    );

    // Operand magnitudes and signs for the incoming instruction.
    always_comb begin
        a_neg = op_is_signed(op_in) & data1_in[WIDTH-1];
        b_neg = op_is_signed(op_in) & data2_in[WIDTH-1];
        a_mag = a_neg ? -data1_in : data1_in;
        b_mag = b_neg ? -data2_in : data2_in;
    end

    // Sign correction of the finished magnitude result.
    always_comb begin
        prod = neg_res ? -acc : acc;
        quo  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        dbz  = div_q && (opnd == '0);
    end

    assign busy_out = (state != IDLE);

    // Control FSM, iteration counter and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            div_q    <= 1'b0;
            neg_res  <= 1'b0;
            neg_a    <= 1'b0;
            acc      <= '0;
            opnd     <= '0;
            done_out <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
            dbz_out  <= 1'b0;
        end else begin
            done_out <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_in && !abort_in) begin
                        state   <= CALC;
                        cnt     <= CNT_W'(WIDTH - 1);
                        div_q   <= op_is_div(op_in);
                        neg_res <= a_neg ^ b_neg;
                        neg_a   <= a_neg;
                        if (op_is_div(op_in)) begin
                            acc  <= {{WIDTH{1'b0}}, a_mag};
                            opnd <= b_mag;
                        end else begin
                            acc  <= {{WIDTH{1'b0}}, b_mag};
                            opnd <= a_mag;
                        end
                    end
                end
                CALC: begin
                    if (abort_in) begin
                        state <= IDLE;
                    end else begin
                        acc <= acc_nxt;
                        if (cnt == '0) begin
                            state <= FIX;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                FIX: begin
                    if (abort_in) begin
                        state <= IDLE;
                    end else begin
                        state    <= DONE;
                        done_out <= 1'b1;
                        dbz_out  <= dbz;
                        if (div_q) begin
                            hi_out <= rem;
                            lo_out <= dbz ? '1 : quo;
                        end else begin
                            hi_out <= prod[2*WIDTH-1:WIDTH];
                            lo_out <= prod[WIDTH-1:0];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed corner cases,
// abort/reset/ignored-start scenarios, then random operations.
module tb_ex_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_in = 1'b0;
    logic [1:0]   op_in = 2'b00;
    logic [W-1:0] data1_in = '0;
    logic [W-1:0] data2_in = '0;
    logic         abort_in = 1'b0;
    logic         busy_out;
    logic         done_out;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;
    logic         dbz_out;

    int errors = 0;
    int checks = 0;

    logic [2*W:0] exp_q[$];
    logic [2*W:0] last_res = '0;
    logic [2*W:0] mon_e;

    ex_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_in (start_in),
        .op_in    (op_in),
        .data1_in (data1_in),
        .data2_in (data2_in),
        .abort_in (abort_in),
        .busy_out (busy_out),
        .done_out (done_out),
        .hi_out   (hi_out),
        .lo_out   (lo_out),
        .dbz_out  (dbz_out)
    );

    always #5 clk = ~clk;

    // Reference: {dbz, hi, lo} from plain integer arithmetic.
    function automatic logic [2*W:0] model(input logic [1:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint       sa;
        longint       sb;
        logic [63:0]  p;
        logic [W-1:0] q;
        logic [W-1:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == OP_MULTU) begin
            p = {32'b0, a} * {32'b0, b};
            return {1'b0, p};
        end
        if (op == OP_MULT) begin
            p = sa * sb;
            return {1'b0, p};
        end
        if (b == '0) return {1'b1, a, 32'hFFFF_FFFF};
        if (op == OP_DIVU) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = '0;
        end else begin
            q = W'(sa / sb);
            r = W'(sa % sb);
        end
        return {1'b0, r, q};
    endfunction

    task automatic check(input string name, input logic [2*W:0] got,
                         input logic [2*W:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Monitor: every done_out pulse pops one expected result.
    always @(negedge clk) begin
        if (rst_n && done_out) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done got hi=%h lo=%h dbz=%b",
                         hi_out, lo_out, dbz_out);
            end else begin
                mon_e = exp_q.pop_front();
                if ({dbz_out, hi_out, lo_out} !== mon_e) begin
                    errors++;
                    $display("FAIL result got=%h want=%h",
                             {dbz_out, hi_out, lo_out}, mon_e);
                end
            end
        end
    end

    // Issue one op (called at a negedge) and wait for its completion.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit poke,
                          input bit lat);
        int n;
        int busy_n;
        op_in    = op;
        data1_in = a;
        data2_in = b;
        start_in = 1'b1;
        exp_q.push_back(model(op, a, b));
        @(negedge clk);
        start_in = 1'b0;
        n = 1;
        busy_n = 0;
        while (n <= 100) begin
            if (busy_out) busy_n++;
            if (done_out) break;
            if (poke && n == 5) begin
                start_in = 1'b1;
                op_in    = ~op;
                data1_in = $urandom;
                data2_in = $urandom;
            end
            if (poke && n == 6) start_in = 1'b0;
            @(negedge clk);
            n++;
        end
        if (n > 100) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got=none want=done");
        end else begin
            if (lat) begin
                check("done_latency", 65'(n), 65'(W + 2));
                check("busy_cycles", 65'(busy_n), 65'(W + 2));
            end
            if (poke) begin
                start_in = 1'b1;
                data1_in = $urandom;
                data2_in = $urandom;
            end
        end
        @(negedge clk);
        start_in = 1'b0;
        check("idle_after_done", {63'b0, busy_out, done_out}, '0);
        last_res = model(op, a, b);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        repeat (3) @(negedge clk);
        check("reset_state",
              {busy_out, done_out, dbz_out, hi_out, lo_out} >> 1, '0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        check("multu_max", {1'b0, hi_out, lo_out},
              {1'b0, 64'hFFFF_FFFE_0000_0001});
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        check("mult_neg", {1'b0, hi_out, lo_out},
              {1'b0, 64'hFFFF_FFFF_FFFF_FFEB});
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        check("div_neg", {1'b0, hi_out, lo_out},
              {1'b0, 64'hFFFF_FFFF_FFFF_FFFD});
        run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
        run_op(OP_DIVU, 32'h1234, 32'd0, 1'b0, 1'b0);
        check("divu_zero", {dbz_out, hi_out, lo_out},
              {1'b1, 32'h1234, 32'hFFFF_FFFF});
        run_op(OP_MULTU, 32'd2, 32'd3, 1'b0, 1'b0);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0);
        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);

        op_in    = OP_MULTU;
        data1_in = 32'd5;
        data2_in = 32'd5;
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        repeat (9) @(negedge clk);
        abort_in = 1'b1;
        @(negedge clk);
        abort_in = 1'b0;
        check("abort_calc_busy", {64'b0, busy_out}, '0);
        check("abort_calc_hold", {dbz_out, hi_out, lo_out}, last_res);
        run_op(OP_MULTU, 32'd7, 32'd9, 1'b0, 1'b0);

        op_in    = OP_DIVU;
        data1_in = 32'd77;
        data2_in = 32'd5;
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        repeat (32) @(negedge clk);
        abort_in = 1'b1;
        @(negedge clk);
        abort_in = 1'b0;
        check("abort_fix_busy", {64'b0, busy_out}, '0);
        check("abort_fix_hold", {dbz_out, hi_out, lo_out}, last_res);

        start_in = 1'b1;
        abort_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        abort_in = 1'b0;
        check("abort_beats_start", {64'b0, busy_out}, '0);

        op_in    = OP_DIV;
        data1_in = 32'hDEAD_BEEF;
        data2_in = 32'd13;
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_mid_op",
              {busy_out, done_out, dbz_out, hi_out, lo_out} >> 1, '0);
        rst_n = 1'b1;
        last_res = '0;
        @(negedge clk);

        run_op(OP_DIVU, 32'hCAFE_F00D, 32'd321, 1'b1, 1'b0);
        run_op(OP_MULT, 32'hFFFF_0001, 32'h0001_FFFF, 1'b1, 1'b0);

        for (int i = 0; i < 60; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 32'd1;
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb, 1'b0, 1'b0);
        end

        repeat (5) @(negedge clk);
        check("queue_empty", 65'(exp_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
